// File: rtl/fft_iter.sv
// fft_iter: iterative radix-2 decimation-in-time FFT engine.
// Loads N_POINTS complex samples into a bit-reversed register buffer, runs
// log2(N_POINTS) stages through one shared butterfly (one per cycle), then
// streams the bins out in natural order.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   / in_ready_o   input sample handshake
//   in_re_i      / in_im_i      signed input sample, Q1.FRAC_BITS
//   out_valid_o  / out_ready_i  output bin handshake
//   out_re_o     / out_im_o     signed output bin, DATA_WIDTH bits, 0 when idle
//   out_last_o   marks bin N_POINTS-1
//   busy_o       high while computing or unloading
//
// Build option: define FFT_STAGE_SCALE_EN to halve every butterfly output
// (round half up), giving an overall 1/N scaling.

module fft_iter #(
   parameter int unsigned N_POINTS   = 8,
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH = 21,
   parameter int unsigned FRAC_BITS  = 15
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic signed [IN_WIDTH-1:0]   in_re_i,
   input  logic signed [IN_WIDTH-1:0]   in_im_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic signed [DATA_WIDTH-1:0] out_re_o,
   output logic signed [DATA_WIDTH-1:0] out_im_o,
   output logic                         out_last_o,
   output logic                         busy_o
);

   localparam int unsigned LOG2N = $clog2(N_POINTS);
   localparam int unsigned HALF  = N_POINTS / 2;
   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned SW    = $clog2(LOG2N + 1);
   localparam int unsigned TWW   = FRAC_BITS + 1;
   localparam int unsigned PW    = DW + TWW + 1;
`ifdef FFT_STAGE_SCALE_EN
   localparam int unsigned DW2    = DW + 2;
   localparam int unsigned MIN_DW = IN_WIDTH + 1;
`else
   localparam int unsigned MIN_DW = IN_WIDTH + LOG2N + 1;
`endif

   // Elaboration-time parameter checks
   if (DW < MIN_DW) begin : g_dw_check
      $error("fft_iter: DATA_WIDTH too small for the transform bit growth");
   end
   if (N_POINTS < 8 || N_POINTS > 64 || (1 << LOG2N) != N_POINTS) begin : g_n_check
      $error("fft_iter: N_POINTS must be a power of two in 8..64");
   end
   if (FRAC_BITS < 1 || FRAC_BITS > 29) begin : g_frac_check
      $error("fft_iter: FRAC_BITS out of range");
   end

   // sin/cos in Q30 of u*2*pi/64, u in [0,32). The angle is folded into
   // [0, pi/4] so a five-term Taylor series is far below one output LSB.
   function automatic longint trig_q30(input int unsigned u, input logic want_sin);
      int unsigned v;
      logic        neg_cos;
      logic        swap;
      longint      x, x2, term, s, c, r_sin, r_cos;
      v       = u;
      neg_cos = 1'b0;
      swap    = 1'b0;
      if (v > 16) begin
         v       = 32 - v;
         neg_cos = 1'b1;
      end
      if (v > 8) begin
         v    = 16 - v;
         swap = 1'b1;
      end
      x    = longint'(v) * 64'sd105414357;
      x2   = (x * x) >>> 30;
      s    = x;
      term = x;
      for (int n = 1; n <= 5; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      c    = 64'sd1 <<< 30;
      term = c;
      for (int n = 1; n <= 5; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
         c    = c + term;
      end
      r_sin = swap ? c : s;
      r_cos = swap ? s : c;
      if (neg_cos) r_cos = -r_cos;
      return want_sin ? r_sin : r_cos;
   endfunction

   typedef logic [HALF-1:0][TWW-1:0] tw_tab_t;

   // Twiddle table W_k = cos - j*sin, rounded to FRAC_BITS, +1.0 clamped
   function automatic tw_tab_t tw_table(input logic want_sin);
      tw_tab_t t;
      longint  q;
      longint  lim;
      lim = (64'sd1 <<< FRAC_BITS) - 64'sd1;
      t   = '0;
      for (int k = 0; k < int'(HALF); k++) begin
         q = (trig_q30(k * (64 / N_POINTS), want_sin) + (64'sd1 <<< (29 - FRAC_BITS)))
             >>> (30 - FRAC_BITS);
         if (q > lim) q = lim;
         t[k] = want_sin ? TWW'(-q) : TWW'(q);
      end
      return t;
   endfunction

   localparam tw_tab_t TW_RE = tw_table(1'b0);
   localparam tw_tab_t TW_IM = tw_table(1'b1);
   localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC_BITS - 1);

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < int'(LOG2N); i++) r[i] = v[int'(LOG2N) - 1 - i];
      return r;
   endfunction

   // Butterfly add/sub, optionally halved with round half up
   function automatic logic signed [DW-1:0] bf_out(input logic signed [DW-1:0] x,
                                                   input logic signed [DW-1:0] y,
                                                   input logic             sub);
`ifdef FFT_STAGE_SCALE_EN
      logic signed [DW2-1:0] s;
      s = sub ? (DW2'(x) - DW2'(y)) : (DW2'(x) + DW2'(y));
      return DW'((s + DW2'(1)) >>> 1);
`else
      return sub ? (x - y) : (x + y);
`endif
   endfunction

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

   state_t               state;
   logic [LOG2N-1:0]     load_cnt;
   logic [LOG2N-1:0]     out_cnt;
   logic [LOG2N-2:0]     j_cnt;
   logic [SW-1:0]        stage;
   logic signed [DW-1:0] mem_re [N_POINTS];
   logic signed [DW-1:0] mem_im [N_POINTS];

   logic [LOG2N-1:0]     j_ext, span, pos, addr_a, addr_b;
   logic [LOG2N-2:0]     tw_idx;
   logic signed [TWW-1:0] w_re, w_im;
   logic signed [DW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
   logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;
   logic signed [PW-1:0] p_re, p_im;

   // Butterfly addressing and datapath for the current (stage, j)
   always_comb begin
      j_ext  = {1'b0, j_cnt};
      span   = LOG2N'(1) << stage;
      pos    = j_ext & (span - LOG2N'(1));
      // ((j >> s) << (s+1)) is j<<1 with its low s+1 bits cleared
      addr_a = ((j_ext << 1) & ~((span << 1) - LOG2N'(1))) | pos;
      addr_b = addr_a | span;
      tw_idx = (LOG2N-1)'(pos << (SW'(LOG2N - 1) - stage));
      a_re   = mem_re[addr_a];
      a_im   = mem_im[addr_a];
      b_re   = mem_re[addr_b];
      b_im   = mem_im[addr_b];
      w_re   = TW_RE[tw_idx];
      w_im   = TW_IM[tw_idx];
      p_re   = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
      p_im   = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);
      t_re   = DW'((p_re + RND) >>> FRAC_BITS);
      t_im   = DW'((p_im + RND) >>> FRAC_BITS);
      na_re  = bf_out(a_re, t_re, 1'b0);
      na_im  = bf_out(a_im, t_im, 1'b0);
      nb_re  = bf_out(a_re, t_re, 1'b1);
      nb_im  = bf_out(a_im, t_im, 1'b1);
   end

   // Control FSM, buffer writes and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= ST_LOAD;
         load_cnt    <= '0;
         out_cnt     <= '0;
         j_cnt       <= '0;
         stage       <= '0;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         out_last_o  <= 1'b0;
         busy_o      <= 1'b0;
         out_re_o    <= '0;
         out_im_o    <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid_i && in_ready_o) begin
                  mem_re[bitrev(load_cnt)] <= DW'(in_re_i);
                  mem_im[bitrev(load_cnt)] <= DW'(in_im_i);
                  load_cnt <= load_cnt + LOG2N'(1);
                  if (load_cnt == LOG2N'(N_POINTS - 1)) begin
                     state      <= ST_COMPUTE;
                     in_ready_o <= 1'b0;
                     busy_o     <= 1'b1;
                  end
               end
            end
            ST_COMPUTE: begin
               mem_re[addr_a] <= na_re;
               mem_im[addr_a] <= na_im;
               mem_re[addr_b] <= nb_re;
               mem_im[addr_b] <= nb_im;
               j_cnt <= j_cnt + (LOG2N-1)'(1);
               if (j_cnt == '1) begin
                  stage <= stage + SW'(1);
                  if (stage == SW'(LOG2N - 1)) begin
                     // Bin 0 was finalised by the first butterfly of the last stage
                     stage       <= '0;
                     state       <= ST_UNLOAD;
                     out_valid_o <= 1'b1;
                     out_last_o  <= 1'b0;
                     out_re_o    <= mem_re[0];
                     out_im_o    <= mem_im[0];
                  end
               end
            end
            ST_UNLOAD: begin
               if (out_ready_i) begin
                  out_cnt <= out_cnt + LOG2N'(1);
                  if (out_cnt == LOG2N'(N_POINTS - 1)) begin
                     state       <= ST_LOAD;
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                     out_re_o    <= '0;
                     out_im_o    <= '0;
                     busy_o      <= 1'b0;
                     in_ready_o  <= 1'b1;
                  end else begin
                     out_re_o   <= mem_re[out_cnt + LOG2N'(1)];
                     out_im_o   <= mem_im[out_cnt + LOG2N'(1)];
                     out_last_o <= (out_cnt + LOG2N'(1)) == LOG2N'(N_POINTS - 1);
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule
